// File: rtl/instr_fetch.sv
// Purpose : instruction fetch sequencer; one memory read per accepted start, flags misaligned PCs and memory timeouts.
// Latency : start sampled at edge 0 -> O_mem_req after edge 0; ack sampled at edge k -> O_valid/O_pc_advance for the cycle after edge k.
// Backpress: no start is accepted outside IDLE; O_mem_req is held with a stable O_mem_addr until ack, flush or timeout.
//
// Ports:
//   I_clk, I_reset             clock and asynchronous active-high reset
//   I_start, I_pc              fetch request and its address (sampled when accepted in IDLE)
//   I_flush                    abort an outstanding fetch; beats a same-cycle start or ack
//   I_clear                    leave FAULT
//   O_mem_addr, O_mem_req      memory read request towards instruction memory
//   I_mem_ack, I_mem_data      memory response, data valid in the ack cycle
//   O_instr                    last fetched instruction, held until the next accepted ack
//   O_valid, O_pc_advance      coincident 1-cycle pulses after a completed fetch
//   O_busy                     high in every state except IDLE
//   O_fault, O_fault_cause     FAULT indication; cause 01 misaligned, 10 timeout

module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_start,
    input  logic [ADDR_W-1:0] I_pc,
    input  logic              I_flush,
    input  logic              I_clear,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic              O_mem_req,
    input  logic              I_mem_ack,
    input  logic [DATA_W-1:0] I_mem_data,
    output logic [DATA_W-1:0] O_instr,
    output logic              O_valid,
    output logic              O_pc_advance,
    output logic              O_busy,
    output logic              O_fault,
    output logic [1:0]        O_fault_cause
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    // Counter value during the last BUSY cycle in which an ack is still accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    // Every output is a register updated alongside the state, so each one
    // reflects the state entered at the most recent edge.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            O_mem_addr    <= '0;
            O_mem_req     <= 1'b0;
            O_instr       <= '0;
            O_valid       <= 1'b0;
            O_pc_advance  <= 1'b0;
            O_busy        <= 1'b0;
            O_fault       <= 1'b0;
            O_fault_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A flush in the same cycle suppresses the start.
                    if (I_start && !I_flush) begin
                        O_busy <= 1'b1;
                        if (I_pc[0]) begin
                            // Odd address: fault without ever touching memory.
                            r_state       <= S_FAULT;
                            O_fault       <= 1'b1;
                            O_fault_cause <= CAUSE_MISALIGN;
                        end else begin
                            r_state    <= S_BUSY;
                            r_cnt      <= '0;
                            O_mem_addr <= I_pc;
                            O_mem_req  <= 1'b1;
                        end
                    end
                end

                S_BUSY: begin
                    if (I_flush) begin
                        // Any ack in this cycle is dropped; O_instr keeps its value.
                        r_state   <= S_IDLE;
                        O_mem_req <= 1'b0;
                        O_busy    <= 1'b0;
                    end else if (I_mem_ack) begin
                        r_state      <= S_DONE;
                        O_instr      <= I_mem_data;
                        O_mem_req    <= 1'b0;
                        O_valid      <= 1'b1;
                        O_pc_advance <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= S_FAULT;
                        O_mem_req     <= 1'b0;
                        O_fault       <= 1'b1;
                        O_fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Single-cycle completion; a start seen here is not accepted.
                    r_state      <= S_IDLE;
                    O_valid      <= 1'b0;
                    O_pc_advance <= 1'b0;
                    O_busy       <= 1'b0;
                end

                S_FAULT: begin
                    if (I_clear) begin
                        r_state       <= S_IDLE;
                        O_fault       <= 1'b0;
                        O_fault_cause <= CAUSE_NONE;
                        O_busy        <= 1'b0;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    O_mem_req     <= 1'b0;
                    O_valid       <= 1'b0;
                    O_pc_advance  <= 1'b0;
                    O_busy        <= 1'b0;
                    O_fault       <= 1'b0;
                    O_fault_cause <= CAUSE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : directed-vector bench for instr_fetch, one task per scenario.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled there as well.
// Backpress: every wait on the DUT is bounded by a cycle budget.

module tb_instr_fetch;

    logic        I_clk;
    logic        I_reset;
    logic        I_start;
    logic [15:0] I_pc;
    logic        I_flush;
    logic        I_clear;
    logic [15:0] O_mem_addr;
    logic        O_mem_req;
    logic        I_mem_ack;
    logic [15:0] I_mem_data;
    logic [15:0] O_instr;
    logic        O_valid;
    logic        O_pc_advance;
    logic        O_busy;
    logic        O_fault;
    logic [1:0]  O_fault_cause;

    int vec_cnt = 0;
    int err_cnt = 0;

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .I_clk         (I_clk),
        .I_reset       (I_reset),
        .I_start       (I_start),
        .I_pc          (I_pc),
        .I_flush       (I_flush),
        .I_clear       (I_clear),
        .O_mem_addr    (O_mem_addr),
        .O_mem_req     (O_mem_req),
        .I_mem_ack     (I_mem_ack),
        .I_mem_data    (I_mem_data),
        .O_instr       (O_instr),
        .O_valid       (O_valid),
        .O_pc_advance  (O_pc_advance),
        .O_busy        (O_busy),
        .O_fault       (O_fault),
        .O_fault_cause (O_fault_cause)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic test_reset();
        I_reset = 1'b1;
        tick();
        vec_cnt++;
        if ({O_mem_req, O_valid, O_pc_advance, O_busy, O_fault} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b want 00000", {O_mem_req, O_valid, O_pc_advance, O_busy, O_fault});
        end
        vec_cnt++;
        if (O_mem_addr !== 16'h0000 || O_instr !== 16'h0000 || O_fault_cause !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_data: addr=%h instr=%h cause=%b want 0000 0000 00", O_mem_addr, O_instr, O_fault_cause);
        end
        I_reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        I_pc = 16'h0010; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        vec_cnt++;
        if (O_mem_req !== 1'b1 || O_mem_addr !== 16'h0010 || O_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b want 1 0010 1", O_mem_req, O_mem_addr, O_busy);
        end
        tick();                                   // second BUSY cycle
        vec_cnt++;
        if (O_mem_req !== 1'b1 || O_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_wait: req=%b valid=%b want 1 0", O_mem_req, O_valid);
        end
        I_mem_ack = 1'b1; I_mem_data = 16'hA5C3;
        tick();
        I_mem_ack = 1'b0; I_mem_data = 16'h0000;
        vec_cnt++;
        if (O_valid !== 1'b1 || O_pc_advance !== 1'b1 || O_instr !== 16'hA5C3 || O_mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_done: valid=%b adv=%b instr=%h req=%b want 1 1 a5c3 0", O_valid, O_pc_advance, O_instr, O_mem_req);
        end
        tick();
        vec_cnt++;
        if (O_valid !== 1'b0 || O_pc_advance !== 1'b0 || O_busy !== 1'b0 || O_instr !== 16'hA5C3) begin
            err_cnt++;
            $display("FAIL basic_idle: valid=%b adv=%b busy=%b instr=%h want 0 0 0 a5c3", O_valid, O_pc_advance, O_busy, O_instr);
        end
    endtask

    task automatic test_timeout();
        int n;
        I_pc = 16'h0020; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        n = 0;
        while (O_busy && !O_fault && n < 40) begin
            n++;
            tick();
        end
        vec_cnt++;
        if (n !== 15) begin
            err_cnt++;
            $display("FAIL timeout_cycles: got %0d busy cycles want 15", n);
        end
        vec_cnt++;
        if (O_fault !== 1'b1 || O_fault_cause !== 2'b10 || O_mem_req !== 1'b0 || O_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_fault: fault=%b cause=%b req=%b valid=%b want 1 10 0 0", O_fault, O_fault_cause, O_mem_req, O_valid);
        end
        // Start must be ignored while faulted.
        I_pc = 16'h0000; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        vec_cnt++;
        if (O_fault !== 1'b1 || O_mem_req !== 1'b0 || O_fault_cause !== 2'b10) begin
            err_cnt++;
            $display("FAIL fault_hold: fault=%b req=%b cause=%b want 1 0 10", O_fault, O_mem_req, O_fault_cause);
        end
        I_clear = 1'b1;
        tick();
        I_clear = 1'b0;
        vec_cnt++;
        if (O_fault !== 1'b0 || O_fault_cause !== 2'b00 || O_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL timeout_clear: fault=%b cause=%b busy=%b want 0 00 0", O_fault, O_fault_cause, O_busy);
        end
    endtask

    task automatic test_misaligned();
        I_pc = 16'h0033; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        vec_cnt++;
        if (O_fault !== 1'b1 || O_fault_cause !== 2'b01 || O_mem_req !== 1'b0 || O_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL misalign_fault: fault=%b cause=%b req=%b busy=%b want 1 01 0 1", O_fault, O_fault_cause, O_mem_req, O_busy);
        end
        tick();
        vec_cnt++;
        if (O_mem_req !== 1'b0 || O_fault !== 1'b1) begin
            err_cnt++;
            $display("FAIL misalign_hold: req=%b fault=%b want 0 1", O_mem_req, O_fault);
        end
        I_clear = 1'b1;
        tick();
        I_clear = 1'b0;
        vec_cnt++;
        if (O_fault !== 1'b0 || O_fault_cause !== 2'b00) begin
            err_cnt++;
            $display("FAIL misalign_clear: fault=%b cause=%b want 0 00", O_fault, O_fault_cause);
        end
    endtask

    task automatic test_flush();
        // Start together with flush in IDLE: no fetch begins.
        I_pc = 16'h0040; I_start = 1'b1; I_flush = 1'b1;
        tick();
        I_flush = 1'b0;
        vec_cnt++;
        if (O_busy !== 1'b0 || O_mem_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_start: busy=%b req=%b want 0 0", O_busy, O_mem_req);
        end
        tick();                                   // start alone now accepted
        I_start = 1'b0;
        vec_cnt++;
        if (O_mem_req !== 1'b1 || O_mem_addr !== 16'h0040) begin
            err_cnt++;
            $display("FAIL flush_req: req=%b addr=%h want 1 0040", O_mem_req, O_mem_addr);
        end
        I_flush = 1'b1; I_mem_ack = 1'b1; I_mem_data = 16'h1234;
        tick();
        I_flush = 1'b0; I_mem_ack = 1'b0; I_mem_data = 16'h0000;
        vec_cnt++;
        if (O_busy !== 1'b0 || O_valid !== 1'b0 || O_mem_req !== 1'b0 || O_instr !== 16'hA5C3) begin
            err_cnt++;
            $display("FAIL flush_race: busy=%b valid=%b req=%b instr=%h want 0 0 0 a5c3", O_busy, O_valid, O_mem_req, O_instr);
        end
    endtask

    task automatic test_reset_midfetch();
        I_pc = 16'h0050; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        #2;
        I_reset = 1'b1;
        #1;
        vec_cnt++;
        if ({O_mem_req, O_valid, O_pc_advance, O_busy, O_fault} !== 5'b0 ||
            O_mem_addr !== 16'h0000 || O_instr !== 16'h0000 || O_fault_cause !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_async: flags=%b addr=%h instr=%h cause=%b want 00000 0000 0000 00",
                     {O_mem_req, O_valid, O_pc_advance, O_busy, O_fault}, O_mem_addr, O_instr, O_fault_cause);
        end
        I_reset = 1'b0;
        tick();
        I_pc = 16'h0000; I_start = 1'b1;
        tick();
        I_start = 1'b0;
        I_mem_ack = 1'b1; I_mem_data = 16'hBEEF;
        tick();
        I_mem_ack = 1'b0; I_mem_data = 16'h0000;
        vec_cnt++;
        if (O_valid !== 1'b1 || O_instr !== 16'hBEEF) begin
            err_cnt++;
            $display("FAIL reset_refetch: valid=%b instr=%h want 1 beef", O_valid, O_instr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pc;
        logic [15:0] exp_addr [3];
        logic [15:0] exp_data [3];
        int          ack_cycle [3];
        exp_addr  = '{16'hFFFC, 16'hFFFE, 16'h0000};
        exp_data  = '{16'h1111, 16'h2222, 16'h3333};
        ack_cycle = '{15, 1, 3};
        pc = 16'hFFFC;
        for (int i = 0; i < 3; i++) begin
            I_pc = pc; I_start = 1'b1;
            tick();
            I_start = 1'b0;
            vec_cnt++;
            if (O_mem_req !== 1'b1 || O_mem_addr !== exp_addr[i]) begin
                err_cnt++;
                $display("FAIL b2b_addr%0d: req=%b addr=%h want 1 %h", i, O_mem_req, O_mem_addr, exp_addr[i]);
            end
            for (int c = 1; c < ack_cycle[i]; c++) tick();
            I_mem_ack = 1'b1; I_mem_data = exp_data[i];
            tick();
            I_mem_ack = 1'b0; I_mem_data = 16'h0000;
            vec_cnt++;
            if (O_valid !== 1'b1 || O_pc_advance !== 1'b1 || O_fault !== 1'b0 || O_instr !== exp_data[i]) begin
                err_cnt++;
                $display("FAIL b2b_done%0d: valid=%b adv=%b fault=%b instr=%h want 1 1 0 %h",
                         i, O_valid, O_pc_advance, O_fault, O_instr, exp_data[i]);
            end
            if (O_pc_advance === 1'b1) pc = pc + 16'd2;
            // Start during DONE must not be taken.
            I_start = 1'b1;
            tick();
            I_start = 1'b0;
            vec_cnt++;
            if (O_busy !== 1'b0 || O_mem_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_done_start%0d: busy=%b req=%b want 0 0", i, O_busy, O_mem_req);
            end
        end
        vec_cnt++;
        if (pc !== 16'h0002) begin
            err_cnt++;
            $display("FAIL b2b_pc: got %h want 0002", pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_reset = 1'b0; I_start = 1'b0; I_pc = 16'h0000; I_flush = 1'b0;
        I_clear = 1'b0; I_mem_ack = 1'b0; I_mem_data = 16'h0000;
        #1;
        test_reset();
        test_basic();
        test_timeout();
        test_misaligned();
        test_flush();
        test_reset_midfetch();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
